// File: rtl/la_stdlib_pkg.sv
// rtl/la_stdlib_pkg.sv - shared encodings for the la_* standard-cell consumer blocks
//
// Purpose: filter FSM state encoding used by la_deglitch.
package la_stdlib_pkg;

  // STABLE: synchronised level agrees with z. PEND: a candidate change is being timed.
  typedef enum logic {
    LA_DG_STABLE = 1'b0,
    LA_DG_PEND   = 1'b1
  } la_dg_state_e;

endpackage

// File: rtl/la_sync.sv
// rtl/la_sync.sv - generic asynchronous-reset synchroniser flop chain
//
// Purpose: brings an asynchronous level into the clk domain through STAGES flops.
// No filtering happens inside the chain.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous reset, active-high; chain loads RESET_VAL
//   in     in  asynchronous level
//   out    out level delayed by STAGES flops
module la_sync #(
  parameter string PROP      = "DEFAULT",
  parameter int    STAGES    = 2,
  parameter logic  RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  assign chain_d = {chain_q[STAGES-2:0], in};
  assign out     = chain_q[STAGES-1];

  // Non-default property strings are reserved for technology-mapped synchroniser
  // cells; until one is mapped both branches use the behavioural chain.
  generate
    if (PROP == "DEFAULT") begin : g_default
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          chain_q <= {STAGES{RESET_VAL}};
        end else begin
          chain_q <= chain_d;
        end
      end
    end else begin : g_custom
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          chain_q <= {STAGES{RESET_VAL}};
        end else begin
          chain_q <= chain_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/la_deglitch.sv
// rtl/la_deglitch.sv - synchronise, deglitch and edge-event a raw gate output
//
// Purpose: registered consumer of a combinational gate output. The raw level is
// synchronised, changes shorter than thresh cycles are rejected, the clean level is
// presented on z, and each accepted transition is offered as a one-deep event.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  asynchronous reset, active-high
//   in         in  raw level, asynchronous to clk
//   thresh     in  stable cycles required to accept a change (0 behaves as 1)
//   z          out filtered level
//   evt_valid  out edge event pending
//   evt_rise   out polarity of the pending event (1 = rising)
//   evt_ready  in  consumer accepts the event when evt_valid & evt_ready
//   evt_drop   out sticky: an edge was lost because the slot was full
//   drop_clr   in  synchronous clear of evt_drop (a same-cycle drop wins)
module la_deglitch
  import la_stdlib_pkg::*;
#(
  parameter string PROP      = "DEFAULT",
  parameter int    CW        = 4,
  parameter int    STAGES    = 2,
  parameter logic  RESET_VAL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in,
  input  logic [CW-1:0] thresh,
  output logic          z,
  output logic          evt_valid,
  output logic          evt_rise,
  input  logic          evt_ready,
  output logic          evt_drop,
  input  logic          drop_clr
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          s;
  logic [CW-1:0] t_eff;

  la_dg_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q, z_d;
  logic          accept_edge;

  logic          evt_valid_q, evt_valid_d;
  logic          evt_rise_q, evt_rise_d;
  logic          evt_drop_q, evt_drop_d;
  logic          drop_set;

  la_sync #(
    .PROP      (PROP),
    .STAGES    (STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (s)
  );

  assign t_eff = (thresh == '0) ? CW'(1) : thresh;

  // Filter FSM. thresh is compared live against cnt, so a lowered threshold
  // takes effect on the very next PEND cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    z_d         = z_q;
    accept_edge = 1'b0;
    case (state_q)
      LA_DG_STABLE: begin
        if (s != z_q) begin
          state_d = LA_DG_PEND;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      LA_DG_PEND: begin
        if (s == z_q) begin
          state_d = LA_DG_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= t_eff) begin
          state_d     = LA_DG_STABLE;
          cnt_d       = '0;
          z_d         = s;
          accept_edge = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = LA_DG_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LA_DG_STABLE;
      cnt_q   <= '0;
      z_q     <= RESET_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  // One-deep event slot. A consumed slot can be refilled in the same cycle;
  // an edge arriving at a full, stalled slot is lost and flagged instead.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_rise_d  = evt_rise_q;
    drop_set    = 1'b0;
    if (accept_edge) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_rise_d  = z_d;
      end else begin
        drop_set    = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
    evt_drop_d = drop_set | (evt_drop_q & ~drop_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_rise_q  <= 1'b0;
      evt_drop_q  <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_rise_q  <= evt_rise_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  assign z         = z_q;
  assign evt_valid = evt_valid_q;
  assign evt_rise  = evt_rise_q;
  assign evt_drop  = evt_drop_q;

endmodule

// File: tb/tb_la_deglitch.sv
// tb/tb_la_deglitch.sv - self-checking bench for la_deglitch
module tb_la_deglitch;
  import la_stdlib_pkg::*;

  localparam int   CW        = 4;
  localparam int   STAGES    = 2;
  localparam logic RESET_VAL = 1'b0;

  logic          clk;
  logic          reset;
  logic          din;
  logic [CW-1:0] thresh;
  logic          z;
  logic          evt_valid;
  logic          evt_rise;
  logic          evt_ready;
  logic          evt_drop;
  logic          drop_clr;

  int checks = 0;
  int errors = 0;

  logic sb[$];
  bit   use_model = 1'b0;

  la_deglitch #(
    .PROP      ("DEFAULT"),
    .CW        (CW),
    .STAGES    (STAGES),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .thresh    (thresh),
    .z         (z),
    .evt_valid (evt_valid),
    .evt_rise  (evt_rise),
    .evt_ready (evt_ready),
    .evt_drop  (evt_drop),
    .drop_clr  (drop_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of ib drives in before edge i+1; bit i of zb is z expected after that edge.
  task automatic run_vec(input string nm, input int n, input logic [31:0] ib,
                         input logic [31:0] zb);
    for (int i = 0; i < n; i++) begin
      din = ib[i];
      tick();
      check($sformatf("%s z[%0d]", nm, i), {31'b0, z}, {31'b0, zb[i]});
    end
  endtask

  // Event monitor: every handshake pops one expected polarity.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got event rise=%0b expected no event", evt_rise);
      end else begin
        logic exp_rise;
        exp_rise = sb.pop_front();
        check("evt_rise_sb", {31'b0, evt_rise}, {31'b0, exp_rise});
      end
    end
  end

  // Reference model for the randomised phase.
  logic [STAGES-1:0] m_sync;
  logic              m_z, m_pend, m_valid, m_rise, m_drop;
  int                m_cnt, m_t, n_cnt;
  logic              n_z, n_pend, m_ev, m_load, m_lose, m_s;

  assign m_s = m_sync[STAGES-1];

  always_comb begin
    m_t    = (thresh == 0) ? 1 : int'(thresh);
    n_z    = m_z;
    n_pend = m_pend;
    n_cnt  = m_cnt;
    m_ev   = 1'b0;
    if (!m_pend) begin
      if (m_s != m_z) begin
        n_pend = 1'b1;
        n_cnt  = 1;
      end else begin
        n_cnt  = 0;
      end
    end else if (m_s == m_z) begin
      n_pend = 1'b0;
      n_cnt  = 0;
    end else if (m_cnt >= m_t) begin
      n_z    = m_s;
      n_pend = 1'b0;
      n_cnt  = 0;
      m_ev   = 1'b1;
    end else begin
      n_cnt  = m_cnt + 1;
    end
    m_load = m_ev && (!m_valid || evt_ready);
    m_lose = m_ev && m_valid && !evt_ready;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sync  <= {STAGES{RESET_VAL}};
      m_z     <= RESET_VAL;
      m_pend  <= 1'b0;
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_rise  <= 1'b0;
      m_drop  <= 1'b0;
    end else begin
      m_sync  <= {m_sync[STAGES-2:0], din};
      m_z     <= n_z;
      m_pend  <= n_pend;
      m_cnt   <= n_cnt;
      m_valid <= m_load ? 1'b1 : ((m_valid && evt_ready) ? 1'b0 : m_valid);
      if (m_load) m_rise <= n_z;
      m_drop  <= m_lose | (m_drop & ~drop_clr);
      if (m_load && use_model) sb.push_back(n_z);
    end
  end

  always @(negedge clk) begin
    if (use_model && !reset) begin
      check("model_z", {31'b0, z}, {31'b0, m_z});
      check("model_evt_valid", {31'b0, evt_valid}, {31'b0, m_valid});
      check("model_evt_drop", {31'b0, evt_drop}, {31'b0, m_drop});
    end
  end

  initial begin
    reset     = 1'b1;
    din       = 1'b1;
    thresh    = 4'd1;
    evt_ready = 1'b0;
    drop_clr  = 1'b0;

    // 1: reset with in=1, then release; z rises STAGES+2 edges later
    repeat (3) tick();
    check("t1 reset z", {31'b0, z}, 32'd0);
    check("t1 reset evt_valid", {31'b0, evt_valid}, 32'd0);
    check("t1 reset evt_drop", {31'b0, evt_drop}, 32'd0);
    reset = 1'b0;
    run_vec("t1_rise", 5, 32'h1F, 32'h18);
    check("t1 evt_valid", {31'b0, evt_valid}, 32'd1);
    check("t1 evt_rise", {31'b0, evt_rise}, 32'd1);
    sb.push_back(1'b1);
    evt_ready = 1'b1;
    tick();
    check("t1 evt consumed", {31'b0, evt_valid}, 32'd0);

    // 2: glitch rejection and accepted pulse at thresh=4
    sb.push_back(1'b0);
    run_vec("t2_fall", 6, 32'h0, 32'h7);
    thresh = 4'd4;
    run_vec("t2_glitch", 12, 32'h7, 32'h0);
    sb.push_back(1'b1);
    sb.push_back(1'b0);
    run_vec("t2_pulse", 16, 32'h3F, 32'hFC0);

    // 3: thresh=0 behaves as thresh=1
    thresh = 4'd0;
    sb.push_back(1'b1);
    sb.push_back(1'b0);
    run_vec("t3_rise", 6, 32'h3F, 32'h38);
    run_vec("t3_fall", 6, 32'h0, 32'h7);

    // 4: stalled consumer, second edge dropped, then drop_clr
    thresh    = 4'd1;
    evt_ready = 1'b0;
    run_vec("t4", 12, 32'h3F, 32'h1F8);
    check("t4 evt_valid", {31'b0, evt_valid}, 32'd1);
    check("t4 evt_rise held", {31'b0, evt_rise}, 32'd1);
    check("t4 evt_drop", {31'b0, evt_drop}, 32'd1);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    check("t4 drop cleared", {31'b0, evt_drop}, 32'd0);
    check("t4 evt_valid kept", {31'b0, evt_valid}, 32'd1);
    sb.push_back(1'b1);
    evt_ready = 1'b1;
    tick();
    check("t4 evt consumed", {31'b0, evt_valid}, 32'd0);

    // 5: consume and reload in the same cycle as a falling edge
    evt_ready = 1'b0;
    run_vec("t5", 9, 32'h3F, 32'h1F8);
    sb.push_back(1'b1);
    sb.push_back(1'b0);
    evt_ready = 1'b1;
    din       = 1'b0;
    tick();
    check("t5 z", {31'b0, z}, 32'd0);
    check("t5 evt_valid", {31'b0, evt_valid}, 32'd1);
    check("t5 evt_rise", {31'b0, evt_rise}, 32'd0);
    check("t5 evt_drop", {31'b0, evt_drop}, 32'd0);
    tick();
    check("t5 evt consumed", {31'b0, evt_valid}, 32'd0);

    // 6: reset mid-PEND (cnt=2, thresh=5) with an event pending
    thresh    = 4'd5;
    evt_ready = 1'b0;
    run_vec("t6_rise", 10, 32'h3FF, 32'h380);
    run_vec("t6_pend", 4, 32'h0, 32'hF);
    check("t6 pend cnt", dut.cnt_q, 32'd2);
    reset = 1'b1;
    #1;
    check("t6 reset z", {31'b0, z}, {31'b0, RESET_VAL});
    check("t6 reset evt_valid", {31'b0, evt_valid}, 32'd0);
    check("t6 reset cnt", dut.cnt_q, 32'd0);
    check("t6 reset state", {31'b0, dut.state_q}, {31'b0, LA_DG_STABLE});
    repeat (2) tick();
    reset     = 1'b0;
    evt_ready = 1'b1;
    run_vec("t6_after", 8, 32'h0, 32'h0);
    check("directed sb empty", sb.size(), 32'd0);

    // Randomised phase against the reference model
    reset     = 1'b1;
    use_model = 1'b1;
    sb.delete();
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) din = ~din;
      if ($urandom_range(0, 63) == 0) thresh = CW'($urandom_range(0, 5));
      evt_ready = ($urandom_range(0, 2) != 0);
      drop_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end
    evt_ready = 1'b1;
    drop_clr  = 1'b0;
    repeat (30) tick();
    check("random sb drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
